// File: rtl/cordic_fix2float.sv
`default_nettype none
// ============================================================================
// Module      : cordic_fix2float
// Description : Three-stage converter from the CORDIC core's signed Q-format
//               result to an IEEE-754 single-precision word (RNE rounding).
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_fix2float #(
    parameter int FRAC_BITS = 30
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        in_valid,
    input  logic [31:0] datain,
    output logic        out_valid,
    output logic [31:0] result
);

    // Biased exponent of the value when the leading one sits at bit 0.
    localparam logic [7:0] c_EXP_ADJ = 8'(127 - FRAC_BITS);

    // ------------------------------------------------------------------
    // Stage 1: capture, sign and magnitude
    // ------------------------------------------------------------------
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic        r_s1_zero;
    logic [31:0] r_s1_mag;
    logic [31:0] w_abs;

    // Negating 32'h80000000 yields 32'h80000000, which read unsigned is 2^31.
    assign w_abs = datain[31] ? (~datain + 32'd1) : datain;

    always_ff @(posedge clock) begin
        if (aclr) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_mag   <= '0;
        end else if (clk_en) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= datain[31];
            r_s1_zero  <= (datain == 32'd0);
            r_s1_mag   <= w_abs;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: leading-one detection and normalisation
    // ------------------------------------------------------------------
    logic [4:0]  w_lod_pos;
    logic [4:0]  w_shift;
    logic [31:0] w_norm;
    logic [7:0]  w_exp;

    always_comb begin
        w_lod_pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (r_s1_mag[i]) begin
                w_lod_pos = 5'(i);
            end
        end
    end

    assign w_shift = 5'd31 - w_lod_pos;
    assign w_norm  = r_s1_mag << w_shift;
    assign w_exp   = c_EXP_ADJ + {3'b000, w_lod_pos};

    logic        r_s2_valid;
    logic        r_s2_sign;
    logic        r_s2_zero;
    logic [7:0]  r_s2_exp;
    logic [30:0] r_s2_norm;

    // The hidden bit norm[31] is always 1 for non-zero data, so it is dropped.
    always_ff @(posedge clock) begin
        if (aclr) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_norm  <= '0;
        end else if (clk_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_zero  <= r_s1_zero;
            r_s2_exp   <= w_exp;
            r_s2_norm  <= w_norm[30:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round to nearest even and pack
    // ------------------------------------------------------------------
    logic [22:0] w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [30:0] w_exp_frac;
    logic [31:0] w_packed;

    assign w_frac     = r_s2_norm[30:8];
    assign w_guard    = r_s2_norm[7];
    assign w_sticky   = |r_s2_norm[6:0];
    assign w_round_up = w_guard & (w_sticky | w_frac[0]);

    // A carry out of an all-ones fraction ripples into the exponent field.
    assign w_exp_frac = {r_s2_exp, w_frac} + {30'd0, w_round_up};
    assign w_packed   = r_s2_zero ? 32'h0000_0000 : {r_s2_sign, w_exp_frac};

    logic        r_out_valid;
    logic [31:0] r_result;

    always_ff @(posedge clock) begin
        if (aclr) begin
            r_out_valid <= 1'b0;
            r_result    <= 32'h0000_0000;
        end else if (clk_en) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_result <= w_packed;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_cordic_fix2float.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_fix2float
// Description : Self-checking bench for cordic_fix2float (vector table,
//               scoreboard with latency tags, stall/reset sequences, sweep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_fix2float;

    logic        clock;
    logic        aclr;
    logic        clk_en;
    logic        in_valid;
    logic [31:0] datain;
    logic        out_valid;
    logic [31:0] result;

    cordic_fix2float #(.FRAC_BITS(30)) dut (
        .clock     (clock),
        .aclr      (aclr),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .datain    (datain),
        .out_valid (out_valid),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [31:0] expv;
    } vec_t;

    typedef struct {
        logic [31:0] expv;
        int          cnt;
    } sb_t;

    sb_t         sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          en_cnt   = 0;
    logic [31:0] pend_exp = '0;
    logic        prev_ov  = 1'b0;
    logic [31:0] prev_res = '0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: exact double conversion, then round the double to single (RNE).
    function automatic logic [31:0] ref_f(input logic [31:0] d);
        real         r;
        logic [63:0] b;
        int          e;
        logic [31:0] res;
        if (d == 32'd0) return 32'h0;
        r   = real'($signed(d)) / 1073741824.0;
        b   = $realtobits(r);
        e   = int'(b[62:52]) - 1023 + 127;
        res = {b[63], 8'(e), b[51:29]};
        if (b[28] && ((|b[27:0]) || b[29])) res = res + 32'd1;
        return res;
    endfunction

    task automatic step(input logic en, input logic rst, input logic v,
                        input logic [31:0] d, input logic [31:0] e);
        @(negedge clock);
        clk_en   = en;
        aclr     = rst;
        in_valid = v;
        datain   = d;
        pend_exp = e;
    endtask

    // Scoreboard monitor: samples inputs on the edge, outputs 1 time unit later.
    logic        m_en, m_rst, m_v;
    logic [31:0] m_exp;
    always @(posedge clock) begin
        m_en  = clk_en;
        m_rst = aclr;
        m_v   = in_valid;
        m_exp = pend_exp;
        #1;
        if (m_rst) begin
            chk(out_valid == 1'b0, "reset_out_valid", {31'd0, out_valid}, 32'd0);
            chk(result == 32'h0, "reset_result", result, 32'h0);
            sb.delete();
        end else if (m_en) begin
            en_cnt++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_out_valid", result, 32'h0);
                end else begin
                    sb_t it;
                    it = sb.pop_front();
                    chk(result == it.expv, "result", result, it.expv);
                    chk(en_cnt == it.cnt + 2, "latency", 32'(en_cnt), 32'(it.cnt + 2));
                end
            end
            if (m_v) sb.push_back('{expv: m_exp, cnt: en_cnt});
        end else begin
            chk(out_valid == prev_ov, "stall_hold_valid", {31'd0, out_valid}, {31'd0, prev_ov});
            chk(result == prev_res, "stall_hold_result", result, prev_res);
        end
        prev_ov  = out_valid;
        prev_res = result;
    end

    vec_t vecs[8];

    initial begin
        vecs[0] = '{data: 32'h40000000, expv: 32'h3F800000};
        vecs[1] = '{data: 32'hC0000000, expv: 32'hBF800000};
        vecs[2] = '{data: 32'h80000000, expv: 32'hC0000000};
        vecs[3] = '{data: 32'h00000000, expv: 32'h00000000};
        vecs[4] = '{data: 32'h00000001, expv: 32'h30800000};
        vecs[5] = '{data: 32'h40000040, expv: 32'h3F800000};
        vecs[6] = '{data: 32'h400000C0, expv: 32'h3F800002};
        vecs[7] = '{data: 32'h7FFFFFFF, expv: 32'h40000000};

        clk_en   = 1'b1;
        aclr     = 1'b1;
        in_valid = 1'b0;
        datain   = '0;

        // Reset for two cycles, then a single 1.0.
        step(1, 1, 0, 32'h0, 32'h0);
        step(1, 0, 1, 32'h40000000, 32'h3F800000);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 32'h0);

        // Table vectors streamed back-to-back.
        for (int i = 0; i < 8; i++) step(1, 0, 1, vecs[i].data, vecs[i].expv);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 32'h0);

        // Stall after the second edge; valid input while stalled must be ignored.
        step(1, 0, 1, 32'h40000000, 32'h3F800000);
        step(1, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h12345678, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 32'h0);

        // Reset mid-flight: in-flight data and the simultaneous input are dropped.
        step(1, 0, 1, 32'hC0000000, 32'hBF800000);
        step(1, 0, 1, 32'h7FFFFFFF, 32'h40000000);
        step(1, 0, 1, 32'h00000001, 32'h30800000);
        step(1, 1, 1, 32'h40000000, 32'h3F800000);
        step(1, 0, 1, 32'h400000C0, 32'h3F800002);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 32'h0);

        // Random sweep with random valid/enable and occasional reset.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] d;
            logic        en, v, rst;
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) d = ~d + 32'd1;
            if ($urandom_range(0, 63) == 0) d = 32'h0;
            en  = ($urandom_range(0, 9) < 8);
            v   = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            step(en, rst, v, d, ref_f(d));
        end
        for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0, 32'h0);
        @(negedge clock);

        chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
